// File: rtl/adder_seq32.sv
// adder_seq32: sequential ripple adder, one 8-bit slice per clock.
// Valid/ready on both sides; carry is held in a register between slices.
module adder_seq32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic [SLICE:0]   w_add;
  logic [WIDTH-1:0] w_sum_nxt;

  // Slice select and add depend only on registered state.
  always_comb begin
    w_sa      = '0;
    w_sb      = '0;
    w_sum_nxt = r_sum;
    for (int k = 0; k < NS; k++) begin
      if (r_idx == IW'(k)) begin
        w_sa = r_a[k*SLICE +: SLICE];
        w_sb = r_b[k*SLICE +: SLICE];
      end
    end
    w_add = {1'b0, w_sa} + {1'b0, w_sb}
          + {{SLICE{1'b0}}, r_carry};
    for (int k = 0; k < NS; k++) begin
      if (r_idx == IW'(k)) begin
        w_sum_nxt[k*SLICE +: SLICE] = w_add[SLICE-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_carry    <= in_cin;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_sum   <= w_sum_nxt;
          r_carry <= w_add[SLICE];
          if (r_idx == LAST) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          // Accept is blocked on the handshake edge; IDLE opens next cycle.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_carry;

endmodule

// File: tb/tb_adder_seq32.sv
// tb_adder_seq32: directed scenarios plus randomized traffic
// checked against a 33-bit arithmetic reference.
module tb_adder_seq32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adder_seq32 #(.WIDTH(32), .SLICE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand pair, return the first visible result and its latency.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic c, output logic [31:0] s,
                        output logic co, output int lat);
    int guard;
    guard = 0;
    lat = -1;
    s = '0;
    co = 1'b0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = c;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      in_a = $urandom;
      in_b = $urandom;
      in_cin = 1'($urandom_range(1));
      step();
      if (out_valid) begin
        lat = i;
        s = out_sum;
        co = out_cout;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_tests++;
    if ({in_ready, out_valid, out_cout, out_sum} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_async: rdy/vld/cout/sum=%b%b%b %h need 100 00000000",
               in_ready, out_valid, out_cout, out_sum);
    end
    step();
    step();
    n_tests++;
    if ({in_ready, out_valid, out_cout, out_sum} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_hold: rdy/vld/cout/sum=%b%b%b %h need 100 00000000",
               in_ready, out_valid, out_cout, out_sum);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] s;
    logic co;
    int lat;
    out_ready = 1'b1;
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, s, co, lat);
    n_tests++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d need 4", lat);
    end
    n_tests++;
    if ({co, s} !== {1'b0, 32'h0000_0100}) begin
      n_fail++;
      $display("FAIL basic_sum: got %b %h need 0 00000100", co, s);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_idle: vld=%b rdy=%b need vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_ripple();
    logic [31:0] s;
    logic co;
    int lat;
    out_ready = 1'b1;
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, s, co, lat);
    step();
    n_tests++;
    if ({co, s} !== {1'b1, 32'h0} || lat !== 4) begin
      n_fail++;
      $display("FAIL ripple_cin: got %b %h lat %0d need 1 00000000 lat 4", co, s, lat);
    end
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, s, co, lat);
    step();
    n_tests++;
    if ({co, s} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap: got %b %h need 1 00000000", co, s);
    end
    run_op(32'h00FF_00FF, 32'h0001_0001, 1'b1, s, co, lat);
    step();
    n_tests++;
    if ({co, s} !== {1'b0, 32'h0100_0101}) begin
      n_fail++;
      $display("FAIL slice_carry: got %b %h need 0 01000101", co, s);
    end
  endtask

  task automatic test_stall();
    logic [31:0] s;
    logic co;
    int lat;
    int bad;
    out_ready = 1'b0;
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, s, co, lat);
    n_tests++;
    if ({co, s} !== {1'b1, 32'h0} || lat !== 4) begin
      n_fail++;
      $display("FAIL stall_result: got %b %h lat %0d need 1 00000000 lat 4", co, s, lat);
    end
    in_valid = 1'b1;
    in_a = 32'h1;
    in_b = 32'h1;
    in_cin = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b1 || out_sum !== 32'h0 || out_cout !== 1'b1 || in_ready !== 1'b0)
        bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d unstable cycles need 0", bad);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: vld=%b rdy=%b need vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int acc_e[2];
    int hs_e[2];
    logic [31:0] rs[2];
    logic rc[2];
    int acc_n;
    int res_n;
    acc_n = 0;
    res_n = 0;
    acc_e = '{-1, -1};
    hs_e = '{-1, -1};
    rs = '{32'h0, 32'h0};
    rc = '{1'b0, 1'b0};
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 32'h1234_5678;
    in_b = 32'h1111_1111;
    in_cin = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (in_valid && in_ready && acc_n < 2) begin
        acc_e[acc_n] = cyc;
        acc_n++;
      end
      if (out_valid && out_ready && res_n < 2) begin
        rs[res_n] = out_sum;
        rc[res_n] = out_cout;
        hs_e[res_n] = cyc;
        res_n++;
      end
      step();
      if (acc_n == 1) begin
        in_a = 32'h0F0F_0F0F;
        in_b = 32'hF0F0_F0F0;
      end else if (acc_n == 2) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if ({rc[0], rs[0]} !== {1'b0, 32'h2345_6789}) begin
      n_fail++;
      $display("FAIL b2b_first: got %b %h need 0 23456789", rc[0], rs[0]);
    end
    n_tests++;
    if ({rc[1], rs[1]} !== {1'b0, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL b2b_second: got %b %h need 0 ffffffff", rc[1], rs[1]);
    end
    n_tests++;
    if (hs_e[0] != 5 || acc_e[1] != hs_e[0] + 1) begin
      n_fail++;
      $display("FAIL b2b_timing: hs at %0d accept2 at %0d need 5 and 6", hs_e[0], acc_e[1]);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s;
    logic co;
    int lat;
    int bad;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 32'h0102_0304;
    in_b = 32'h1020_3040;
    in_cin = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, out_cout, out_sum} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL midrun_reset: rdy/vld/cout/sum=%b%b%b %h need 100 00000000",
               in_ready, out_valid, out_cout, out_sum);
    end
    #2 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midrun_no_valid: %0d valid cycles need 0", bad);
    end
    run_op(32'h0102_0304, 32'h1020_3040, 1'b1, s, co, lat);
    step();
    n_tests++;
    if ({co, s} !== {1'b0, 32'h1122_3345} || lat !== 4) begin
      n_fail++;
      $display("FAIL midrun_next: got %b %h lat %0d need 0 11223345 lat 4", co, s, lat);
    end
  endtask

  task automatic test_random();
    logic [32:0] q[$];
    logic [32:0] exp;
    int sent;
    int got;
    int cyc;
    logic acc;
    sent = 0;
    got = 0;
    cyc = 0;
    in_valid = 1'b0;
    while (got < 10000 && cyc < 80000) begin
      if (!in_valid) begin
        in_a = $urandom;
        in_b = $urandom;
        in_cin = 1'($urandom_range(1));
        if (sent < 10000 && $urandom_range(7) != 0) in_valid = 1'b1;
      end
      out_ready = ($urandom_range(7) != 0);
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back({1'b0, in_a} + {1'b0, in_b} + {32'h0, in_cin});
        sent++;
      end
      if (out_valid && out_ready) begin
        n_tests++;
        got++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_dup: result %b %h with nothing outstanding", out_cout, out_sum);
        end else begin
          exp = q.pop_front();
          if ({out_cout, out_sum} !== exp) begin
            n_fail++;
            $display("FAIL rand_sum: got %b %h need %b %h",
                     out_cout, out_sum, exp[32], exp[31:0]);
          end
        end
      end
      step();
      cyc++;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 10000 || sent != 10000 || q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: sent %0d got %0d left %0d need 10000 10000 0",
               sent, got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_stall();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
